// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the BeagleBone serial link.
// Timing defaults assume a 100 MHz clock and 115,200 baud, 8N1.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT = 868;
    localparam int unsigned HALF_BIT     = 434;
    localparam int unsigned NUM_BYTES    = 16;
    localparam int unsigned DATA_W       = 8 * NUM_BYTES;
    localparam int unsigned CNT_W        = 10;
    localparam int unsigned BYTE_IDX_W   = $clog2(NUM_BYTES);
    localparam int unsigned BYTE_CNT_W   = $clog2(NUM_BYTES + 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic {
        FRAME_COLLECT = 1'b0,
        FRAME_DONE    = 1'b1
    } frame_state_t;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receive-side bus: serial line in, 128-bit frame out with RECEIVED/ACKNOWLEDGE handshake.
interface uart_rx_frame_if;
    import uart_pkg::*;

    logic              RX;
    logic              ACKNOWLEDGE;
    logic [DATA_W-1:0] DATA;
    logic              RECEIVED;
    logic              FRAME_ERR;
    logic              OVERRUN;

    modport master (
        input  RX,
        input  ACKNOWLEDGE,
        output DATA,
        output RECEIVED,
        output FRAME_ERR,
        output OVERRUN
    );

    modport slave (
        output RX,
        output ACKNOWLEDGE,
        input  DATA,
        input  RECEIVED,
        input  FRAME_ERR,
        input  OVERRUN
    );

endinterface

// File: rtl/uart_rx_byte.sv
// Single-byte 8N1 receiver: RX synchronizer, bit timer and START/DATA/STOP sequencing.
// byte_valid and frame_err are single-cycle strobes coincident with the mid-stop sample.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned BIT_CLKS  = CLKS_PER_BIT,
    parameter int unsigned HALF_CLKS = HALF_BIT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    input  logic       enable,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       rx_fall
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CLKS - 1);

    // [1:0] is the two-flop synchronizer, [2] holds the previous rx_s for edge detection
    logic [2:0]       rx_sync_r;
    logic             rx_s;
    rx_state_t        state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       bit_idx_r, bit_idx_s;
    logic [7:0]       shift_r, shift_s;

    assign rx_s    = rx_sync_r[1];
    assign rx_byte = shift_r;
    assign rx_fall = rx_sync_r[2] & ~rx_s;

    // State, timer, shifter and synchronizer registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_sync_r <= 3'b111;
            state_r   <= RX_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            rx_sync_r <= {rx_sync_r[1:0], RX};
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
        end
    end

    // Next-state logic; every sample point restarts the timer for the next bit
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r + CNT_W'(1);
        bit_idx_s  = bit_idx_r;
        shift_s    = shift_r;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (state_r)
            RX_IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                if (enable && !rx_s) begin
                    state_s = RX_START;
                end else begin
                    state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s     = {CNT_W{1'b0}};
                    bit_idx_s = 3'd0;
                    state_s   = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    state_s = RX_START;
                end
            end
            RX_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s              = {CNT_W{1'b0}};
                    shift_s[bit_idx_r] = rx_s;
                    bit_idx_s          = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        state_s = RX_STOP;
                    end else begin
                        state_s = RX_DATA;
                    end
                end else begin
                    state_s = RX_DATA;
                end
            end
            RX_STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s      = {CNT_W{1'b0}};
                    state_s    = RX_IDLE;
                    byte_valid = rx_s;
                    frame_err  = ~rx_s;
                end else begin
                    state_s = RX_STOP;
                end
            end
            default: begin
                state_s = RX_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/uart_rx_frame.sv
// 16-byte frame receiver: packs bytes from uart_rx_byte into DATA and holds it
// under a RECEIVED/ACKNOWLEDGE handshake, flagging frame errors and overruns.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned BIT_CLKS  = CLKS_PER_BIT,
    parameter int unsigned HALF_CLKS = HALF_BIT
) (
    input  logic             CLK,
    input  logic             RST,
    uart_rx_frame_if.master  bus
);

    logic [7:0]            rx_byte_s;
    logic                  byte_valid_s;
    logic                  frame_err_s;
    logic                  rx_fall_s;
    logic                  collect_s;
    frame_state_t          state_r, state_s;
    logic [BYTE_CNT_W-1:0] count_r, count_s;
    logic [DATA_W-1:0]     data_r, data_s;
    logic                  overrun_r, overrun_s;
    logic                  frame_err_r;

    assign collect_s = (state_r == FRAME_COLLECT);

    uart_rx_byte #(
        .BIT_CLKS  (BIT_CLKS),
        .HALF_CLKS (HALF_CLKS)
    ) u_byte (
        .CLK        (CLK),
        .RST        (RST),
        .RX         (bus.RX),
        .enable     (collect_s),
        .rx_byte    (rx_byte_s),
        .byte_valid (byte_valid_s),
        .frame_err  (frame_err_s),
        .rx_fall    (rx_fall_s)
    );

    // Frame state, assembly register and status flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= FRAME_COLLECT;
            count_r     <= {BYTE_CNT_W{1'b0}};
            data_r      <= {DATA_W{1'b0}};
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            data_r      <= data_s;
            overrun_r   <= overrun_s;
            frame_err_r <= frame_err_s;
        end
    end

    // Byte packing while collecting; DATA is frozen in DONE until acknowledged
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        data_s    = data_r;
        overrun_s = overrun_r;
        case (state_r)
            FRAME_COLLECT: begin
                if (byte_valid_s) begin
                    data_s[{count_r[BYTE_IDX_W-1:0], 3'b000} +: 8] = rx_byte_s;
                    count_s = count_r + BYTE_CNT_W'(1);
                    if (count_r == BYTE_CNT_W'(NUM_BYTES - 1)) begin
                        state_s = FRAME_DONE;
                    end else begin
                        state_s = FRAME_COLLECT;
                    end
                end else if (frame_err_s) begin
                    count_s = {BYTE_CNT_W{1'b0}};
                end else begin
                    count_s = count_r;
                end
            end
            FRAME_DONE: begin
                if (bus.ACKNOWLEDGE) begin
                    count_s   = {BYTE_CNT_W{1'b0}};
                    overrun_s = 1'b0;
                    state_s   = FRAME_COLLECT;
                end else if (rx_fall_s) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun_r;
                end
            end
            default: begin
                state_s = FRAME_COLLECT;
                count_s = {BYTE_CNT_W{1'b0}};
            end
        endcase
    end

    assign bus.DATA      = data_r;
    assign bus.RECEIVED  = (state_r == FRAME_DONE);
    assign bus.FRAME_ERR = frame_err_r;
    assign bus.OVERRUN   = overrun_r;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with a shortened bit time (40 clks/bit) to keep runs short.
module tb_uart_rx_frame;
    import uart_pkg::*;

    localparam int BIT     = 40;
    localparam int HALF    = 20;
    localparam int LAT_OFF = HALF + 3;

    logic CLK = 1'b0;
    logic RST;
    int   checks   = 0;
    int   failures = 0;
    int   rise_off;
    int   ferr_cnt = 0;
    logic [127:0] exp_d;
    logic [127:0] prev_d;

    always #5 CLK = ~CLK;

    uart_rx_frame_if bus();

    uart_rx_frame #(.BIT_CLKS(BIT), .HALF_CLKS(HALF)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (bus.FRAME_ERR) ferr_cnt++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int bclks, input logic stop_bit);
        bus.RX = 1'b0;
        wait_clks(bclks);
        for (int i = 0; i < 8; i++) begin
            bus.RX = b[i];
            wait_clks(bclks);
        end
        bus.RX   = stop_bit;
        rise_off = -1;
        for (int i = 0; i < bclks; i++) begin
            wait_clks(1);
            if (bus.RECEIVED && rise_off < 0) rise_off = i + 1;
        end
        bus.RX = 1'b1;
    endtask

    task automatic send_frame(input logic [127:0] d, input int bclks);
        for (int k = 0; k < 16; k++) send_byte(d[8*k +: 8], bclks, 1'b1);
    endtask

    task automatic ack_and_check(input string tag);
        check_eq({tag, "_rcv_before"}, 128'(bus.RECEIVED), 128'd1);
        bus.ACKNOWLEDGE = 1'b1;
        wait_clks(1);
        bus.ACKNOWLEDGE = 1'b0;
        check_eq({tag, "_rcv_after"}, 128'(bus.RECEIVED), 128'd0);
        check_eq({tag, "_ovr_after"}, 128'(bus.OVERRUN), 128'd0);
        wait_clks(5);
    endtask

    initial begin
        bus.RX          = 1'b1;
        bus.ACKNOWLEDGE = 1'b0;
        RST             = 1'b1;
        wait_clks(5);
        check_eq("rst_data", bus.DATA, 128'd0);
        check_eq("rst_rcv", 128'(bus.RECEIVED), 128'd0);
        check_eq("rst_ferr", 128'(bus.FRAME_ERR), 128'd0);
        check_eq("rst_ovr", 128'(bus.OVERRUN), 128'd0);
        RST = 1'b0;
        wait_clks(10);

        // Frame 1: bytes 0x00..0x0F back-to-back
        send_frame(128'h0F0E0D0C0B0A09080706050403020100, BIT);
        check_eq("f1_latency", 128'(rise_off), 128'(LAT_OFF));
        check_eq("f1_data", bus.DATA, 128'h0F0E0D0C0B0A09080706050403020100);
        wait_clks(50);
        check_eq("f1_frozen", bus.DATA, 128'h0F0E0D0C0B0A09080706050403020100);
        ack_and_check("f1_ack");

        // Frame 2: all 0xA5
        send_frame({16{8'hA5}}, BIT);
        check_eq("f2_latency", 128'(rise_off), 128'(LAT_OFF));
        check_eq("f2_data", bus.DATA, {16{8'hA5}});
        ack_and_check("f2_ack");

        // Short low glitch in IDLE must be rejected at the mid-start sample
        bus.RX = 1'b0;
        wait_clks(12);
        bus.RX = 1'b1;
        wait_clks(100);
        check_eq("glitch_cnt", 128'(dut.count_r), 128'd0);
        check_eq("glitch_state", 128'(dut.u_byte.state_r), 128'(RX_IDLE));
        check_eq("glitch_rcv", 128'(bus.RECEIVED), 128'd0);
        send_frame(128'h123456789ABCDEF0_0FEDCBA987654321, BIT);
        check_eq("f3_data", bus.DATA, 128'h123456789ABCDEF0_0FEDCBA987654321);
        ack_and_check("f3_ack");

        // Fifth byte with low stop bit: one FRAME_ERR pulse, count cleared, old bytes kept
        ferr_cnt = 0;
        for (int k = 0; k < 4; k++) send_byte(8'(8'h10 + k), BIT, 1'b1);
        send_byte(8'h44, BIT, 1'b0);
        wait_clks(2 * BIT);
        check_eq("ferr_pulses", 128'(ferr_cnt), 128'd1);
        check_eq("ferr_cnt", 128'(dut.count_r), 128'd0);
        check_eq("ferr_keep", 128'(bus.DATA[31:0]), 128'h13121110);
        send_frame(128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF, BIT);
        check_eq("f4_data", bus.DATA, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
        check_eq("f4_latency", 128'(rise_off), 128'(LAT_OFF));
        check_eq("f4_ferr", 128'(ferr_cnt), 128'd1);

        // Extra byte while RECEIVED is high
        check_eq("ovr_before", 128'(bus.OVERRUN), 128'd0);
        send_byte(8'h55, BIT, 1'b1);
        wait_clks(BIT);
        check_eq("ovr_set", 128'(bus.OVERRUN), 128'd1);
        check_eq("ovr_data", bus.DATA, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
        ack_and_check("ovr_ack");

        // ACKNOWLEDGE while collecting is ignored; then RST mid-bit of byte 3
        send_byte(8'h01, BIT, 1'b1);
        send_byte(8'h02, BIT, 1'b1);
        bus.ACKNOWLEDGE = 1'b1;
        wait_clks(1);
        bus.ACKNOWLEDGE = 1'b0;
        wait_clks(5);
        check_eq("ack_ignored_cnt", 128'(dut.count_r), 128'd2);
        check_eq("ack_ignored_rcv", 128'(bus.RECEIVED), 128'd0);
        prev_d = bus.DATA;
        check_eq("pre_rst_data", 128'(prev_d[15:0]), 128'h0201);
        bus.RX = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 3; i++) begin
            bus.RX = i[0];
            wait_clks(BIT);
        end
        bus.RX = 1'b1;
        wait_clks(BIT / 2);
        RST = 1'b1;
        wait_clks(1);
        RST = 1'b0;
        check_eq("rst2_data", bus.DATA, 128'd0);
        check_eq("rst2_rcv", 128'(bus.RECEIVED), 128'd0);
        check_eq("rst2_ferr", 128'(bus.FRAME_ERR), 128'd0);
        check_eq("rst2_ovr", 128'(bus.OVERRUN), 128'd0);
        check_eq("rst2_cnt", 128'(dut.count_r), 128'd0);
        wait_clks(3 * BIT);
        send_frame(128'hFFEEDDCCBBAA99887766554433221100, BIT);
        check_eq("f5_data", bus.DATA, 128'hFFEEDDCCBBAA99887766554433221100);
        ack_and_check("f5_ack");

        // Transmitter slightly fast and slightly slow
        for (int k = 0; k < 16; k++) exp_d[8*k +: 8] = 8'(8'h5A + k);
        send_frame(exp_d, BIT - 1);
        wait_clks(BIT);
        check_eq("fast_data", bus.DATA, exp_d);
        ack_and_check("fast_ack");
        for (int k = 0; k < 16; k++) exp_d[8*k +: 8] = 8'(8'hC3 ^ k);
        send_frame(exp_d, BIT + 1);
        wait_clks(BIT);
        check_eq("slow_data", bus.DATA, exp_d);
        ack_and_check("slow_ack");
        check_eq("final_ferr", 128'(ferr_cnt), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
